// File: rtl/inst_fetch.sv
// Instruction fetch stage: sequential PC, one-cycle ROM, 2-entry {pc, inst} buffer, branch redirect.
// Define INST_BYTE_SWAP_EN to byte-reverse each ROM word before it is buffered.
module inst_fetch #(
  parameter logic [31:0] INIT_PC   = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_read_data,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  logic [31:0] pc;
  logic [31:0] inflight_pc;
  logic        inflight;
  logic        squash;
  logic [31:0] buf_pc   [2];
  logic [31:0] buf_inst [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        pop;
  logic        push;
  logic [2:0]  occ;
  logic [31:0] fetch_word;

  // Handshake: an entry moves to the consumer on a cycle where inst_valid and
  // inst_ready are both high; inst/inst_pc stay put while valid is held without ready.
  assign inst_valid = !rst && (count != 2'd0);
  assign inst       = inst_valid ? buf_inst[rd_ptr] : 32'h0;
  assign inst_pc    = inst_valid ? buf_pc[rd_ptr]   : 32'h0;
  assign pop        = inst_valid && inst_ready;

  // Occupancy after this cycle's pop, counting the word still on its way back.
  assign occ      = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign rom_en   = !rst && !branch_flag && (occ < 3'(BUF_DEPTH));
  assign rom_addr = rst ? INIT_PC : pc;

  // A redirect in the return cycle kills the returning word along with the buffer.
  assign push = inflight && !squash && !branch_flag;

`ifdef INST_BYTE_SWAP_EN
  assign fetch_word = {rom_read_data[7:0], rom_read_data[15:8],
                       rom_read_data[23:16], rom_read_data[31:24]};
`else
  assign fetch_word = rom_read_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= INIT_PC;
      inflight_pc <= INIT_PC;
      inflight    <= 1'b0;
      squash      <= 1'b0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
    end else begin
      inflight <= rom_en;
      if (rom_en) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end
      // squash marks the outstanding request as belonging to a redirected stream
      if (branch_flag) begin
        squash <= inflight;
      end else if (rom_en) begin
        squash <= 1'b0;
      end
      if (branch_flag) begin
        pc     <= {branch_target[31:2], 2'b00};
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          buf_pc[wr_ptr]   <= inflight_pc;
          buf_inst[wr_ptr] <= fetch_word;
          wr_ptr           <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed timing scenarios plus random traffic, with a program-order
// reference stream checked on every accepted instruction.
module tb_inst_fetch;

  localparam logic [31:0] INIT = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_read_data = 32'h0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] next_pc = INIT;
  logic [31:0] e_pc;
  logic [31:0] held_pc;
  logic [31:0] held_inst;

  inst_fetch #(.INIT_PC(INIT), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_read_data(rom_read_data), .branch_flag(branch_flag),
    .branch_target(branch_target), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1122_3344;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    logic [31:0] d;
    d = rom_fn(a);
`ifdef INST_BYTE_SWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // ROM: answers one cycle after a request, garbage otherwise
  always @(posedge clk) begin
    if (rom_en) rom_read_data <= rom_fn(rom_addr);
    else        rom_read_data <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: every accepted instruction must be the next one in program order
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      next_pc = INIT;
    end else begin
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          exp_q.push_back(next_pc);
          next_pc = next_pc + 32'd4;
        end
        e_pc = exp_q.pop_front();
        chk("deliver_pc", inst_pc, e_pc);
        chk("deliver_inst", inst, exp_inst(e_pc));
      end
      if (branch_flag) begin
        exp_q.delete();
        next_pc = {branch_target[31:2], 2'b00};
      end
    end
  end

  initial begin
    // reset state
    repeat (3) begin
      step(); #1;
      chk("rst_rom_en", {31'b0, rom_en}, 32'd0);
      chk("rst_rom_addr", rom_addr, INIT);
      chk("rst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
    end

    // reset release: addresses 0,4,8 and first valid in cycle 2
    step(); rst = 1'b0; #1;
    chk("rel_c0_addr", rom_addr, 32'h0);
    chk("rel_c0_en", {31'b0, rom_en}, 32'd1);
    chk("rel_c0_valid", {31'b0, inst_valid}, 32'd0);
    step(); #1;
    chk("rel_c1_addr", rom_addr, 32'h4);
    chk("rel_c1_valid", {31'b0, inst_valid}, 32'd0);
    step(); #1;
    chk("rel_c2_addr", rom_addr, 32'h8);
    chk("rel_c2_valid", {31'b0, inst_valid}, 32'd1);
    chk("rel_c2_pc", inst_pc, 32'h0);
`ifdef INST_BYTE_SWAP_EN
    chk("rel_c2_inst", inst, 32'h4433_2211);
`else
    chk("rel_c2_inst", inst, 32'h1122_3344);
`endif
    repeat (6) begin
      step(); #1;
      chk("stream_valid", {31'b0, inst_valid}, 32'd1);
    end

    // consumer stall for 5 cycles
    step(); inst_ready = 1'b0; #1;
    held_pc = inst_pc;
    held_inst = inst;
    repeat (4) begin
      step(); #1;
      chk("stall_rom_en", {31'b0, rom_en}, 32'd0);
      chk("stall_valid", {31'b0, inst_valid}, 32'd1);
      chk("stall_pc", inst_pc, held_pc);
      chk("stall_inst", inst, held_inst);
    end
    step(); inst_ready = 1'b1; #1;
    chk("release_rom_en", {31'b0, rom_en}, 32'd1);
    repeat (3) begin
      chk("release_valid", {31'b0, inst_valid}, 32'd1);
      step(); #1;
    end

    // branch with a request in flight
    repeat (3) step();
    branch_flag = 1'b1; branch_target = 32'h0000_0102; #1;
    chk("br_rom_en", {31'b0, rom_en}, 32'd0);
    step(); branch_flag = 1'b0; #1;
    chk("br_next_addr", rom_addr, 32'h0000_0100);
    chk("br_next_en", {31'b0, rom_en}, 32'd1);
    chk("br_flushed", {31'b0, inst_valid}, 32'd0);
    step(); #1;
    chk("br_gap", {31'b0, inst_valid}, 32'd0);
    step(); #1;
    chk("br_first_valid", {31'b0, inst_valid}, 32'd1);
    chk("br_first_pc", inst_pc, 32'h0000_0100);

    // back-to-back branches take the last target
    step(); branch_flag = 1'b1; branch_target = 32'h0000_0200; #1;
    chk("bb_en0", {31'b0, rom_en}, 32'd0);
    step(); branch_target = 32'h0000_0303; #1;
    chk("bb_en1", {31'b0, rom_en}, 32'd0);
    step(); branch_flag = 1'b0; #1;
    chk("bb_addr", rom_addr, 32'h0000_0300);

    // PC wrap
    step(); branch_flag = 1'b1; branch_target = 32'hFFFF_FFFE;
    step(); branch_flag = 1'b0; #1;
    chk("wrap_addr0", rom_addr, 32'hFFFF_FFFC);
    step(); #1;
    chk("wrap_addr1", rom_addr, 32'h0000_0000);
    repeat (4) step();

    // reset while the buffer is full
    inst_ready = 1'b0;
    repeat (4) step();
    rst = 1'b1; #1;
    chk("rstfull_valid0", {31'b0, inst_valid}, 32'd0);
    step(); #1;
    chk("rstfull_valid1", {31'b0, inst_valid}, 32'd0);
    step(); rst = 1'b0; inst_ready = 1'b1; #1;
    chk("rstfull_addr", rom_addr, INIT);
    repeat (3) step();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step();
      inst_ready = ($urandom_range(0, 9) < 7);
      branch_flag = ($urandom_range(0, 19) == 0);
      branch_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
      rst = ($urandom_range(0, 149) == 0);
    end
    step(); branch_flag = 1'b0; rst = 1'b0; inst_ready = 1'b1;
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter INIT_PC, default 32'h0000_0000: the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, fixed at 2: the number of instruction buffer entries.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port rom_en, output, 1 bit: ROM read request for this cycle.
REQ-006 SHALL have port rom_addr, output, 32 bits: byte address of the ROM read.
REQ-007 SHALL have port rom_read_data, input, 32 bits: ROM data, valid in the cycle after a request.
REQ-008 SHALL have port branch_flag, input, 1 bit: redirect request.
REQ-009 SHALL have port branch_target, input, 32 bits: redirect address.
REQ-010 SHALL have port inst_valid, output, 1 bit: the buffer head holds an instruction.
REQ-011 SHALL have port inst_ready, input, 1 bit: the consumer accepts the head.
REQ-012 SHALL have port inst, output, 32 bits: the head instruction word.
REQ-013 SHALL have port inst_pc, output, 32 bits: the byte address of the head instruction.

Function
REQ-014 SHALL hold a fetch PC register, an in-flight flag with its PC, and a 2-entry FIFO of {pc, inst}.
REQ-015 SHALL drive rom_en and rom_addr combinationally: rom_addr = PC; rom_en = !rst && !branch_flag && (count + inflight - pop <= 1), where pop = inst_valid && inst_ready.
REQ-016 SHALL, on each edge where rom_en=1, set inflight=1, record the in-flight PC, and advance PC by 4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-017 SHALL write rom_read_data and the in-flight PC into the FIFO tail at the end of the cycle after a request, unless that request was squashed.
REQ-018 SHALL have a latency from request to inst_valid of 2 cycles; with inst_ready held high, steady-state throughput SHALL be 1 instruction per cycle.
REQ-019 SHALL drive inst_valid as (count != 0), with inst and inst_pc taken from the head entry.
REQ-020 SHALL hold inst and inst_pc stable while inst_valid && !inst_ready.
REQ-021 SHALL handle a simultaneous push and pop in the same cycle with count unchanged.
REQ-022 SHALL maintain count + inflight <= 2 at all times; no FIFO overflow is possible.
REQ-023 SHALL, when branch_flag=1:
  - deassert rom_en in that cycle;
  - set PC to {branch_target[31:2], 2'b00};
  - clear the FIFO at the edge;
  - mark any in-flight request squashed so its returning data is dropped.
REQ-024 SHALL treat a pop coinciding with branch_flag as accepted by the consumer; flush still clears all entries.
REQ-025 SHALL resume fetching from the new PC in the cycle after branch_flag.
REQ-026 SHALL have back-to-back branch_flag cycles take the last target; no fetch occurs until branch_flag drops.

Reset
REQ-027 SHALL, on rst=1 at an edge, set PC=INIT_PC, count=0, inflight=0 and squash=0.
REQ-028 SHALL, during rst=1, drive rom_en=0, rom_addr=INIT_PC, inst_valid=0, inst=0 and inst_pc=0.
REQ-029 SHALL discard data returning in the first cycle after reset.
REQ-030 SHALL issue the first request (addr=INIT_PC) in the first cycle with rst=0.

Configuration
REQ-031 SHALL, with INST_BYTE_SWAP_EN defined, set the stored inst to {d[7:0], d[15:8], d[23:16], d[31:24]} of rom_read_data.
REQ-032 SHALL, without INST_BYTE_SWAP_EN, store rom_read_data unmodified.

Verification
REQ-033 SHALL cover reset release with inst_ready=1 -> rom_addr 0x0,0x4,0x8 in cycles 0,1,2; inst_valid from cycle 2 with inst_pc=0x0, one instruction per cycle thereafter.
REQ-034 SHALL cover inst_ready=0 for 5 cycles -> exactly 2 entries buffered, rom_en=0 once full, inst/inst_pc stable; on release, in-order delivery with no PC skipped.
REQ-035 SHALL cover branch_flag=1 with target 0x0000_0102 while an entry is in flight -> next rom_addr=0x0000_0100, the in-flight word is never presented, and the next inst_pc=0x100.
REQ-036 SHALL cover PC at 0xFFFF_FFFC -> next rom_addr=0x0000_0000.
REQ-037 SHALL cover rom_read_data=0x11223344 -> inst=0x44332211 with INST_BYTE_SWAP_EN defined, and 0x11223344 without it.
REQ-038 SHALL cover rst asserted with 2 entries buffered and a request in flight -> inst_valid=0 next cycle, and the first inst_pc after release is INIT_PC.
